// File: rtl/cla_multicycle_adder_ctrl_if.sv
// Operand/result handshake bundle for the multicycle CLA sequencer.
// master drives operands and out_ready; slave is the sequencer.
interface cla_multicycle_adder_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;
  logic             P_out;
  logic             G_out;
  logic             busy;

  modport master (
    output in_valid, a, b, sub, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, overflow, P_out, G_out, busy
  );

  modport slave (
    input  in_valid, a, b, sub, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, overflow, P_out, G_out, busy
  );
endinterface

// File: rtl/cla_multicycle_adder_ctrl.sv
// Time-shares one SLICE-bit carry-lookahead slice over a WIDTH-bit add/sub,
// LSB slice first, accumulating word-level group propagate/generate.
module cla_multicycle_adder_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8,
  parameter int unsigned CNT_W = 2
) (
  input logic                       clk,
  input logic                       rst_n,
  cla_multicycle_adder_ctrl_if.slave bus
);
  localparam int unsigned BEATS = WIDTH / SLICE;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   beat_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               carry_q;
  logic               p_acc_q;
  logic               g_acc_q;
  logic [WIDTH-1:0]   sum_q;
  logic               c_out_q;
  logic               ovf_q;
  logic               p_out_q;
  logic               g_out_q;
  logic               out_valid_q;
  logic               busy_q;

  logic [SLICE-1:0]   a_s;
  logic [SLICE-1:0]   b_s;
  logic [SLICE-1:0]   p_s;
  logic [SLICE-1:0]   g_s;
  logic [SLICE-1:0]   c_s;
  logic [SLICE-1:0]   sum_s;
  logic               cy_s;
  logic               gs_s;
  logic               ps_s;
  logic               last_beat;

  // Slice datapath for the current beat: carries, sum, and slice P/G.
  always_comb begin
    a_s = '0;
    b_s = '0;
    for (int k = 0; k < BEATS; k++) begin
      if (beat_q == CNT_W'(k)) begin
        a_s = a_q[k*SLICE +: SLICE];
        b_s = b_q[k*SLICE +: SLICE];
      end
    end
    p_s  = a_s ^ b_s;
    g_s  = a_s & b_s;
    c_s  = '0;
    cy_s = carry_q;
    gs_s = 1'b0;
    for (int i = 0; i < SLICE; i++) begin
      c_s[i] = cy_s;
      cy_s   = g_s[i] | (p_s[i] & cy_s);
      gs_s   = g_s[i] | (p_s[i] & gs_s);
    end
    ps_s      = &p_s;
    sum_s     = p_s ^ c_s;
    last_beat = (beat_q == CNT_W'(BEATS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      p_acc_q     <= 1'b1;
      g_acc_q     <= 1'b0;
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      p_out_q     <= 1'b0;
      g_out_q     <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.b ^ {WIDTH{bus.sub}};
            carry_q <= bus.sub | bus.c_in;
            beat_q  <= '0;
            p_acc_q <= 1'b1;
            g_acc_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < BEATS; k++) begin
            if (beat_q == CNT_W'(k)) sum_q[k*SLICE +: SLICE] <= sum_s;
          end
          carry_q <= cy_s;
          p_acc_q <= p_acc_q & ps_s;
          g_acc_q <= gs_s | (ps_s & g_acc_q);
          if (last_beat) begin
            // Carry into the MSB is the ripple carry at the top bit of the last slice.
            c_out_q     <= cy_s;
            ovf_q       <= c_s[SLICE-1] ^ cy_s;
            p_out_q     <= p_acc_q & ps_s;
            g_out_q     <= gs_s | (ps_s & g_acc_q);
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= DONE;
          end else begin
            beat_q <= beat_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.c_out     = c_out_q;
  assign bus.overflow  = ovf_q;
  assign bus.P_out     = p_out_q;
  assign bus.G_out     = g_out_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_cla_multicycle_adder_ctrl.sv
// Scoreboard bench for cla_multicycle_adder_ctrl: directed vectors, backpressure
// and mid-run reset abort.
module tb_cla_multicycle_adder_ctrl;
  localparam int unsigned WIDTH = 32;

  typedef struct packed {
    logic [31:0] sum;
    logic        c;
    logic        ov;
    logic        p;
    logic        g;
  } exp_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
    exp_t        e;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  cla_multicycle_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

  cla_multicycle_adder_ctrl #(.WIDTH(WIDTH), .SLICE(8), .CNT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t        sb_q[$];
  int unsigned acc_q[$];
  int          n_vec  = 0;
  int          n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: latency on each rising out_valid, result compare on each handshake.
  logic        prev_ov = 1'b0;
  exp_t        e_mon;
  int unsigned t_mon;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && !prev_ov && acc_q.size() > 0) begin
        t_mon = acc_q.pop_front();
        chk("latency", cyc - t_mon, 32'd4);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          e_mon = sb_q.pop_front();
          chk("sum",      bus.sum,             e_mon.sum);
          chk("c_out",    32'(bus.c_out),      32'(e_mon.c));
          chk("overflow", 32'(bus.overflow),   32'(e_mon.ov));
          chk("P_out",    32'(bus.P_out),      32'(e_mon.p));
          chk("G_out",    32'(bus.G_out),      32'(e_mon.g));
        end
      end
    end
    prev_ov = bus.out_valid;
  end

  // Issue one transaction; called and returns at posedge+1.
  task automatic send(input vec_t v, input bit track);
    int n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    bus.a        = v.a;
    bus.b        = v.b;
    bus.sub      = v.sub;
    bus.c_in     = v.cin;
    bus.in_valid = 1'b1;
    if (track) sb_q.push_back(v.e);
    @(posedge clk); #1;
    if (track) acc_q.push_back(cyc);
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
    bus.sub      = 1'($urandom_range(0, 1));
    bus.c_in     = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() > 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb_q.size() > 0) chk("drain_timeout", 32'(sb_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  //                 a             b             sub   cin   sum           c     ov    P     G
  vec_t vecs[7] = '{
    '{32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, '{32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1}},
    '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, '{32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0}},
    '{32'h00000005, 32'h00000007, 1'b1, 1'b0, '{32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0}},
    '{32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, '{32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0}},
    '{32'h12345678, 32'h11111111, 1'b0, 1'b1, '{32'h2345678A, 1'b0, 1'b0, 1'b0, 1'b0}},
    '{32'h80000000, 32'h00000001, 1'b1, 1'b0, '{32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b1}},
    '{32'h5A5A5A5A, 32'h5A5A5A5A, 1'b1, 1'b0, '{32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0}}
  };

  initial begin
    int n;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.c_in      = 1'b0;
    bus.out_ready = 1'b1;

    #12;
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_sum",       bus.sum,            32'd0);
    chk("rst_c_out",     32'(bus.c_out),     32'd0);
    chk("rst_overflow",  32'(bus.overflow),  32'd0);
    chk("rst_P_out",     32'(bus.P_out),     32'd0);
    chk("rst_G_out",     32'(bus.G_out),     32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) send(vecs[i], 1'b1);
    drain();

    // Backpressure: hold DONE, pulse in_valid, then release on the exit cycle.
    bus.out_ready = 1'b0;
    send(vecs[2], 1'b1);
    chk("run_busy", 32'(bus.busy), 32'd1);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = $urandom;
      bus.b        = $urandom;
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
      chk("bp_sum",       bus.sum,            32'hFFFFFFFE);
      chk("bp_busy",      32'(bus.busy),      32'd0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    chk("bp_exit_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("bp_idle_in_ready",  32'(bus.in_ready),  32'd1);
    chk("bp_idle_out_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_idle_busy",      32'(bus.busy),      32'd0);
    chk("bp_sum_kept",       bus.sum,            32'hFFFFFFFE);
    drain();

    // Reset asserted while beat 2 is in flight.
    send(vecs[1], 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_busy", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_in_ready",  32'(bus.in_ready),  32'd1);
    chk("abort_busy",      32'(bus.busy),      32'd0);
    chk("abort_sum",       bus.sum,            32'd0);
    chk("abort_c_out",     32'(bus.c_out),     32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    send(vecs[1], 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
